// File: rtl/seq_divider_8bit_if.sv
// Start/busy/done handshake bundle between the sequencer (master) and the divider (slave).
interface seq_divider_8bit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_8bit.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock, WIDTH iterations.
module seq_divider_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_divider_8bit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PW    = WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_p, w_p_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [WIDTH-1:0] r_divisor, w_divisor_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [WIDTH-1:0] r_quot, w_quot_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic             r_dz, w_dz_nxt;
    logic             w_accept;
    logic [PW-1:0]    w_p_shift;
    logic [PW-1:0]    w_trial;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_p       <= '0;
            r_q       <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_dz      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_p       <= w_p_nxt;
            r_q       <= w_q_nxt;
            r_divisor <= w_divisor_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_quot    <= w_quot_nxt;
            r_rem     <= w_rem_nxt;
            r_dz      <= w_dz_nxt;
        end
    end

    // Partial remainder never reaches the divisor, so WIDTH bits hold it; the trial needs one more for the borrow.
    always_comb begin
        w_state_nxt   = r_state;
        w_p_nxt       = r_p;
        w_q_nxt       = r_q;
        w_divisor_nxt = r_divisor;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_quot_nxt    = r_quot;
        w_rem_nxt     = r_rem;
        w_dz_nxt      = r_dz;
        w_accept      = 1'b0;
        w_p_shift     = {r_p, r_q[WIDTH-1]};
        w_trial       = w_p_shift - {1'b0, r_divisor};

        case (r_state)
            S_IDLE: begin
                w_accept = bus.start;
            end
            S_RUN: begin
                if (r_divisor == '0) begin
                    w_state_nxt = S_FIN;
                    w_quot_nxt  = '1;
                    w_rem_nxt   = r_q;
                    w_dz_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_q_nxt   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
                    w_p_nxt   = w_trial[WIDTH] ? w_p_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_state_nxt = S_FIN;
                        w_quot_nxt  = w_q_nxt;
                        w_rem_nxt   = w_p_nxt;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
                w_accept    = bus.start;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Acceptance from IDLE or FIN (back-to-back) loads operands and starts iterating.
        if (w_accept) begin
            w_state_nxt   = S_RUN;
            w_p_nxt       = '0;
            w_q_nxt       = bus.dividend;
            w_divisor_nxt = bus.divisor;
            w_cnt_nxt     = '0;
            w_dz_nxt      = 1'b0;
            w_busy_nxt    = 1'b1;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dz;
endmodule

// File: doc/seq_divider_8bit.md
Name: seq_divider_8bit

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the team's combinational 8-bit adder/subtractor.
- Each iteration performs one trial subtraction of the divisor from the partial remainder, then either keeps the result or restores it.
- Sits beside the adder/subtractor in the arithmetic datapath.
- Driven by a start/busy/done handshake from the sequencing logic.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits; must be at least 2.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled on rising edge of clk.
dividend  input  WIDTH  unsigned dividend; captured when start is accepted.
divisor  input  WIDTH  unsigned divisor; captured when start is accepted.
busy  output  1  high while a division is in progress.
done  output  1  one-cycle pulse; quotient and remainder valid.
quotient  output  WIDTH  result quotient; held until next accepted start.
remainder  output  WIDTH  result remainder; held until next accepted start.
div_by_zero  output  1  set with done when captured divisor was 0; held until next accepted start.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal counter and partial remainder cleared.
  - Reset mid-division aborts the division; no done is issued.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge k: latch operands, clear div_by_zero, go to RUN; busy=1 from edge k.
  - If the latched divisor is 0: go straight to FIN at edge k+1 (no iterations).
- RUN:
  - Internal registers: partial remainder P (WIDTH+1 bits) and quotient shift register Q (WIDTH bits).
  - Initialise at acceptance: P=0, Q=dividend, count=0.
  - Per edge:
    - P' = {P[WIDTH-1:0], Q[WIDTH-1]}.
    - Q shifts left by one.
    - T = P' - {1'b0, divisor}, computed at WIDTH+1 bits.
    - If T[WIDTH]==0: P=T and Q[0]=1.
    - Else: P=P' (restore) and Q[0]=0.
    - count increments.
  - After exactly WIDTH iteration edges (edges k+1..k+WIDTH), go to FIN.
- FIN (one cycle, entered at edge k+WIDTH, or k+1 for divide-by-zero):
  - done=1, busy=0.
  - quotient=Q, remainder=P[WIDTH-1:0].
  - Divide-by-zero result: quotient = all ones, remainder = dividend, div_by_zero=1.
  - Next edge: return to IDLE (done=0). If start=1 at that edge, accept it exactly as in IDLE (back-to-back operation).
- Latency: done is high in the cycle after edge k+WIDTH; for WIDTH=8 that is 8 edges after acceptance. Divide-by-zero: 1 edge.
- Handshake rules:
  - start while busy=1 is ignored.
  - Operand inputs are don't-care except at the accepted edge.
  - Operand changes during RUN have no effect.
- Output hold: quotient, remainder and div_by_zero keep their last values through IDLE and RUN. They are updated only on FIN entry, or cleared by reset.
- Simultaneous rst and start: rst wins; start is not accepted.
- Arithmetic:
  - Purely unsigned.
  - The trial subtraction uses WIDTH+1 bits so that its borrow is bit WIDTH.
  - No overflow is possible for a non-zero divisor.
- Invariant for a non-zero divisor: dividend == quotient*divisor + remainder and remainder < divisor.

Test Plan:
- Basic division: rst 2 cycles; start with dividend=100, divisor=7 → busy for 8 cycles, done 8 edges after acceptance, quotient=14, remainder=2, div_by_zero=0.
- Edge operands:
  - 255/1 → quotient=255, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 255/255 → quotient=1, remainder=0.
- Divide by zero: 37/0 → done 1 edge after acceptance, quotient=255, remainder=37, div_by_zero=1; a following 10/3 clears div_by_zero and gives quotient=3, remainder=1.
- Protocol:
  - Start 200/9; pulse start with 50/5 at iteration 4 → ignored; result quotient=22, remainder=2.
  - Start held high through FIN → second division accepted at the FIN→IDLE edge.
- Reset mid-operation: start 100/7; assert rst at iteration 3 → busy=0, done never pulses, outputs all 0; a subsequent 9/2 gives quotient=4, remainder=1.
- Randomised check: 1000 random operand pairs, divisor ≠ 0, compared against the reference model; assert the invariant; done is exactly one cycle wide; busy and done are never high together.
